// File: rtl/enigma_engine.sv
// ---------------------------------------------------------------------------
// enigma_engine
//   Multi-cycle rotor-cipher engine. NUM_ROTORS rotors over an ALPHA-symbol
//   alphabet, plus a shared reflector and plugboard. All wirings, rotor
//   positions and notches are loaded at run time through a configuration
//   port. One character is processed at a time:
//     IDLE -> STEP -> FWD (one cycle per rotor) -> REFL
//          -> BWD (one cycle per rotor) -> OUT -> IDLE
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_sym   plaintext input handshake
//   out_valid/out_ready/out_sym ciphertext output handshake
//   out_err                    qualifies out_valid: input symbol was >= ALPHA
//   step_en                    1 = rotors step per character, 0 = frozen key
//   cfg_we/cfg_sel/cfg_addr/cfg_data  table write port (honoured in IDLE only)
//     cfg_sel <  N   : rotor k forward wiring (inverse kept in step)
//     cfg_sel == N   : reflector, paired write
//     cfg_sel == N+1 : plugboard, paired write
//     cfg_sel == N+2 : rotor position, cfg_addr = rotor index
//     cfg_sel == N+3 : rotor notch,    cfg_addr = rotor index
//   dbg_state                  current FSM state encoding
// ---------------------------------------------------------------------------
module enigma_engine #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int SYM_W      = 5,
  parameter int SEL_W      = $clog2(NUM_ROTORS + 4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_err,
  input  logic             step_en,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [SYM_W-1:0] cfg_addr,
  input  logic [SYM_W-1:0] cfg_data,
  output logic [2:0]       dbg_state
);

  localparam int RW = $clog2(NUM_ROTORS);

  localparam logic [RW-1:0]    LAST_ROT   = RW'(NUM_ROTORS - 1);
  localparam logic [SYM_W:0]   ALPHA_W    = (SYM_W + 1)'(ALPHA);
  localparam logic [SYM_W-1:0] ALPHA_MAX  = SYM_W'(ALPHA - 1);
  localparam logic [SEL_W-1:0] SEL_REFL   = SEL_W'(NUM_ROTORS);
  localparam logic [SEL_W-1:0] SEL_PLUG   = SEL_W'(NUM_ROTORS + 1);
  localparam logic [SEL_W-1:0] SEL_POS    = SEL_W'(NUM_ROTORS + 2);
  localparam logic [SEL_W-1:0] SEL_NOTCH  = SEL_W'(NUM_ROTORS + 3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_FWD  = 3'd2,
    S_REFL = 3'd3,
    S_BWD  = 3'd4,
    S_OUT  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Datapath registers
  logic [RW-1:0]    rot_q;        // rotor currently being traversed
  logic [SYM_W-1:0] x_q;          // symbol in flight
  logic             err_q;        // latched symbol was out of range
  logic [SYM_W-1:0] out_sym_q;
  logic             out_valid_q;
  logic             out_err_q;

  // Key storage
  logic [SYM_W-1:0] fwd_q   [NUM_ROTORS][ALPHA];
  logic [SYM_W-1:0] inv_q   [NUM_ROTORS][ALPHA];
  logic [SYM_W-1:0] refl_q  [ALPHA];
  logic [SYM_W-1:0] plug_q  [ALPHA];
  logic [SYM_W-1:0] pos_q   [NUM_ROTORS];
  logic [SYM_W-1:0] notch_q [NUM_ROTORS];

  // -------------------------------------------------------------------------
  // Handshake and configuration qualifiers
  // -------------------------------------------------------------------------
  logic accept;
  logic cfg_ok;
  logic tbl_ok;
  logic rot_ok;

  // A simultaneous config write takes priority over accepting a symbol.
  assign accept = (state_q == S_IDLE) && in_valid && !cfg_we;
  assign cfg_ok = (state_q == S_IDLE) && cfg_we;
  assign tbl_ok = (cfg_addr < SYM_W'(ALPHA)) && (cfg_data < SYM_W'(ALPHA));
  assign rot_ok = (cfg_addr < SYM_W'(NUM_ROTORS)) && (cfg_data < SYM_W'(ALPHA));

  // -------------------------------------------------------------------------
  // Stepping decisions, all taken from pre-step positions
  // -------------------------------------------------------------------------
  logic [NUM_ROTORS-1:0] at_notch;
  logic [NUM_ROTORS-1:0] step_vec;
  logic [SYM_W-1:0]      pos_inc [NUM_ROTORS];

  // NOTE: every signal assigned in always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    step_vec = '0;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      at_notch[k] = (pos_q[k] == notch_q[k]);
      pos_inc[k]  = (pos_q[k] == ALPHA_MAX) ? '0 : pos_q[k] + 1'b1;
    end
    step_vec[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++) begin
      // Middle rotors sitting on their own notch step again (double step).
      step_vec[k] = at_notch[k-1] || ((k < NUM_ROTORS - 1) && at_notch[k]);
    end
  end

  // -------------------------------------------------------------------------
  // One rotor traversal: x -> (table[(x+pos) mod A] - pos) mod A
  // -------------------------------------------------------------------------
  logic [SYM_W-1:0] pos_cur;
  logic [SYM_W:0]   idx_sum;
  logic [SYM_W:0]   idx_mod;
  logic [SYM_W-1:0] idx;
  logic [SYM_W-1:0] lut;
  logic [SYM_W:0]   sub_sum;
  logic [SYM_W:0]   sub_mod;
  logic [SYM_W-1:0] rot_out;

  always_comb begin
    pos_cur = pos_q[rot_q];
    idx_sum = {1'b0, x_q} + {1'b0, pos_cur};
    idx_mod = (idx_sum >= ALPHA_W) ? idx_sum - ALPHA_W : idx_sum;
    idx     = idx_mod[SYM_W-1:0];
    lut     = (state_q == S_BWD) ? inv_q[rot_q][idx] : fwd_q[rot_q][idx];
    // Adding ALPHA before subtracting keeps the intermediate non-negative.
    sub_sum = {1'b0, lut} + ALPHA_W - {1'b0, pos_cur};
    sub_mod = (sub_sum >= ALPHA_W) ? sub_sum - ALPHA_W : sub_sum;
    rot_out = sub_mod[SYM_W-1:0];
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_STEP;
      S_STEP: state_d = S_FWD;
      S_FWD:  if (rot_q == LAST_ROT) state_d = S_REFL;
      S_REFL: state_d = S_BWD;
      S_BWD:  if (rot_q == '0) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    dbg_state = state_q;
    out_valid = out_valid_q;
    out_sym   = out_sym_q;
    out_err   = out_err_q;
  end

  // -------------------------------------------------------------------------
  // Key storage: reset to identity wirings, written by config or stepping
  // -------------------------------------------------------------------------
  // NOTE: the tables are reset explicitly (flop arrays, not RAM) because an
  // asynchronous reset must restore the identity key immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        pos_q[k]   <= '0;
        notch_q[k] <= ALPHA_MAX;
        for (int a = 0; a < ALPHA; a++) begin
          fwd_q[k][a] <= SYM_W'(a);
          inv_q[k][a] <= SYM_W'(a);
        end
      end
      for (int a = 0; a < ALPHA; a++) begin
        refl_q[a] <= SYM_W'(a ^ 1);
        plug_q[a] <= SYM_W'(a);
      end
    end else if (cfg_ok) begin
      if (cfg_sel < SEL_REFL) begin
        if (tbl_ok) begin
          fwd_q[cfg_sel][cfg_addr] <= cfg_data;
          inv_q[cfg_sel][cfg_data] <= cfg_addr;
        end
      end else if (cfg_sel == SEL_REFL) begin
        if (tbl_ok) begin
          refl_q[cfg_addr] <= cfg_data;
          refl_q[cfg_data] <= cfg_addr;
        end
      end else if (cfg_sel == SEL_PLUG) begin
        if (tbl_ok) begin
          plug_q[cfg_addr] <= cfg_data;
          plug_q[cfg_data] <= cfg_addr;
        end
      end else if (cfg_sel == SEL_POS) begin
        if (rot_ok) pos_q[cfg_addr] <= cfg_data;
      end else if (cfg_sel == SEL_NOTCH) begin
        if (rot_ok) notch_q[cfg_addr] <= cfg_data;
      end
    end else if ((state_q == S_STEP) && step_en && !err_q) begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        if (step_vec[k]) pos_q[k] <= pos_inc[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: symbol in flight and registered output
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q       <= '0;
      x_q         <= '0;
      err_q       <= 1'b0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q   <= in_sym;
            err_q <= (in_sym >= SYM_W'(ALPHA));
          end
        end
        S_STEP: begin
          rot_q <= '0;
          if (!err_q) x_q <= plug_q[x_q];
        end
        S_FWD: begin
          if (!err_q) x_q <= rot_out;
          // Counter parks on the last rotor, where the backward pass begins.
          if (rot_q != LAST_ROT) rot_q <= rot_q + 1'b1;
        end
        S_REFL: begin
          if (!err_q) x_q <= refl_q[x_q];
        end
        S_BWD: begin
          if (rot_q != '0) begin
            if (!err_q) x_q <= rot_out;
            rot_q <= rot_q - 1'b1;
          end else begin
            // Final inverse lookup and plugboard folded into one edge.
            out_sym_q   <= err_q ? x_q : plug_q[rot_out];
            out_err_q   <= err_q;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_engine.sv
// ---------------------------------------------------------------------------
// tb_enigma_engine
//   Directed bench for enigma_engine (N=3, ALPHA=26). Inputs are driven and
//   outputs sampled on the falling clock edge. Expected values are worked out
//   by hand from the default identity key (output = refl[x] = x^1) or from the
//   small shift-rotor key loaded at the end.
// ---------------------------------------------------------------------------
module tb_enigma_engine;

  localparam int N    = 3;
  localparam int A    = 26;
  localparam int SW   = 5;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SW-1:0]   in_sym = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [SW-1:0]   out_sym;
  logic            out_err;
  logic            step_en = 1'b1;
  logic            cfg_we = 1'b0;
  logic [SELW-1:0] cfg_sel = '0;
  logic [SW-1:0]   cfg_addr = '0;
  logic [SW-1:0]   cfg_data = '0;
  logic [2:0]      dbg_state;

  enigma_engine #(
    .NUM_ROTORS(N),
    .ALPHA     (A),
    .SYM_W     (SW),
    .SEL_W     (SELW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sym   (in_sym),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym  (out_sym),
    .out_err  (out_err),
    .step_en  (step_en),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic cfg_write(input int sel, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = SELW'(sel);
    cfg_addr = SW'(addr);
    cfg_data = SW'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic set_pos(input int p0, input int p1, input int p2);
    cfg_write(N + 2, 0, p0);
    cfg_write(N + 2, 1, p1);
    cfg_write(N + 2, 2, p2);
  endtask

  task automatic check_pos(input string tag, input int p0, input int p1, input int p2);
    check({tag, "_pos0"}, int'(dut.pos_q[0]), p0);
    check({tag, "_pos1"}, int'(dut.pos_q[1]), p1);
    check({tag, "_pos2"}, int'(dut.pos_q[2]), p2);
  endtask

  // Encrypt one symbol with out_ready held high; lat counts edges from the
  // accept edge to the edge that raised out_valid.
  task automatic encrypt(input int sym, output int o, output int e, output int lat);
    in_valid = 1'b1;
    in_sym   = SW'(sym);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("encrypt_done", int'(out_valid), 1);
    o = int'(out_sym);
    e = int'(out_err);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int o, e, lat, c, wait_cnt;

    // ---------------- Reset defaults ----------------
    #12;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sym",   int'(out_sym),   0);
    check("rst_out_err",   int'(out_err),   0);
    check("rst_state",     int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    encrypt(0, o, e, lat);
    check("dflt_out",     o,   1);
    check("dflt_err",     e,   0);
    check("dflt_latency", lat, 8);
    check_pos("dflt", 1, 0, 0);
    check("dflt_ready_after", int'(in_ready), 1);

    // ---------------- Double step ----------------
    set_pos(25, 25, 0);
    encrypt(0, o, e, lat);
    check("dstep_out", o, 1);
    check_pos("dstep", 0, 0, 1);
    step_en = 1'b0;
    encrypt(4, o, e, lat);
    check("frozen_out", o, 5);
    check_pos("frozen", 0, 0, 1);
    step_en = 1'b1;

    // ---------------- Out-of-range symbol ----------------
    encrypt(27, o, e, lat);
    check("oor_out",     o,   27);
    check("oor_err",     e,   1);
    check("oor_latency", lat, 8);
    check_pos("oor", 0, 0, 1);

    // ---------------- Backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sym    = SW'(2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("bp_valid_rise", int'(out_valid), 1);
    check("bp_out",        int'(out_sym),   3);
    for (int i = 0; i < 5; i++) begin
      cfg_we   = (i < 2);
      cfg_sel  = SELW'(N + 2);
      cfg_addr = SW'(0);
      cfg_data = SW'(9);
      @(negedge clk);
      check("bp_hold_sym",   int'(out_sym),   3);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready),  0);
    end
    cfg_we = 1'b0;
    check("bp_cfg_ignored", int'(dut.pos_q[0]), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready),  1);
    check("bp_release_state", int'(dbg_state), 0);

    // ---------------- Reset during FWD ----------------
    cfg_write(N + 1, 0, 5);
    in_valid = 1'b1;
    in_sym   = SW'(0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (dbg_state != 3'd2 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid_reach_fwd", int'(dbg_state), 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid),       0);
    check("mid_rst_ready", int'(in_ready),        1);
    check("mid_rst_state", int'(dbg_state),       0);
    check("mid_rst_plug",  int'(dut.plug_q[0]),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    encrypt(0, o, e, lat);
    check("mid_rst_reencrypt", o, 1);

    // ---------------- Reciprocity ----------------
    // Rotor 0: x+3, rotor 1: x+5, rotor 2: identity; plugboard swaps 7<->2.
    for (int a = 0; a < A; a++) begin
      cfg_write(0, a, (a + 3) % A);
      cfg_write(1, a, (a + 5) % A);
    end
    cfg_write(N + 1, 7, 2);
    set_pos(0, 0, 0);
    encrypt(7, c, e, lat);
    check("recip_enc7", c, 3);
    set_pos(0, 0, 0);
    encrypt(c, o, e, lat);
    check("recip_dec", o, 7);
    for (int x = 0; x < A; x++) begin
      set_pos(0, 0, 0);
      encrypt(x, c, e, lat);
      check($sformatf("recip_nofix_%0d", x), int'(c != x), 1);
      set_pos(0, 0, 0);
      encrypt(c, o, e, lat);
      check($sformatf("recip_back_%0d", x), o, x);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
